// File: rtl/clk_en_bank.sv
// Bank of independent programmable clock-enable dividers. Each channel emits a one-cycle
// ce pulse per period and a divided clock with programmable high time.

module clk_en_ch #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          sync_i,
  input  logic          load_i,
  input  logic [CW-1:0] div_i,
  input  logic [CW-1:0] high_i,
  output logic          ce_o,
  output logic          clk_o,
  output logic          pend_o
);
  typedef struct packed {
    logic [CW-1:0] per;
    logic [CW-1:0] hi;
  } cfg_t;

  cfg_t          act_q, act_d, pnd_q, pnd_d, new_cfg;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d, ce_q, ce_d, clk_q, clk_d;
  logic          term, xfer;

  // Config only moves pending->active at a period boundary, on sync, or while idle,
  // so the active period/duty never changes partway through a running period.
  always_comb begin
    new_cfg = '{per: div_i, hi: high_i};
    term    = en_i && (cnt_q == act_q.per);
    xfer    = term || sync_i || !en_i;
    cnt_d   = (!en_i || sync_i || term) ? '0 : cnt_q + 1'b1;
    ce_d    = term && !sync_i;
    clk_d   = en_i && (cnt_q < act_q.hi);
    act_d   = act_q;
    pnd_d   = pnd_q;
    pend_d  = pend_q;
    if (load_i) begin
      pnd_d = new_cfg;
      if (xfer) begin
        act_d  = new_cfg;
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (xfer && pend_q) begin
      act_d  = pnd_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q  <= '0;
      pnd_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ce_q   <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      act_q  <= act_d;
      pnd_q  <= pnd_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ce_q   <= ce_d;
      clk_q  <= clk_d;
    end
  end

  assign ce_o   = ce_q;
  assign clk_o  = clk_q;
  assign pend_o = pend_q;
endmodule

module clk_en_bank #(
  parameter int NCH = 4,
  parameter int CW  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    en,
  input  logic [NCH*CW-1:0] div_i,
  input  logic [NCH*CW-1:0] high_i,
  input  logic [NCH-1:0]    load,
  input  logic              sync,
  output logic [NCH-1:0]    ce_o,
  output logic [NCH-1:0]    clk_o,
  output logic [NCH-1:0]    pend_o
);
  logic [NCH-1:0][CW-1:0] div_v, high_v;

  assign div_v  = div_i;
  assign high_v = high_i;

  // sync is the only signal shared between channels.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_en_ch #(.CW(CW)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .en_i  (en[g]),
      .sync_i(sync),
      .load_i(load[g]),
      .div_i (div_v[g]),
      .high_i(high_v[g]),
      .ce_o  (ce_o[g]),
      .clk_o (clk_o[g]),
      .pend_o(pend_o[g])
    );
  end
endmodule

// File: tb/tb_clk_en_bank.sv
// Directed scenarios followed by random traffic, every cycle checked against a
// period/phase reference model of each channel.

module tb_clk_en_bank;
  localparam int NCH = 4;
  localparam int CW  = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    en = '0;
  logic [NCH*CW-1:0] div_i = '0;
  logic [NCH*CW-1:0] high_i = '0;
  logic [NCH-1:0]    load = '0;
  logic              sync = 1'b0;
  logic [NCH-1:0]    ce_o, clk_o, pend_o;

  clk_en_bank #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .div_i(div_i), .high_i(high_i),
    .load(load), .sync(sync), .ce_o(ce_o), .clk_o(clk_o), .pend_o(pend_o)
  );

  always #5 clk = ~clk;

  // Model: phase within period, active/pending period length and high time.
  int phase [NCH];
  int period[NCH];
  int high  [NCH];
  int pperiod[NCH];
  int phigh [NCH];
  bit pend  [NCH];
  logic [NCH-1:0] m_ce = '0, m_clk = '0, m_pend = '0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      int d, h;
      bit at_end, moving;
      d = int'(div_i[i*CW +: CW]);
      h = int'(high_i[i*CW +: CW]);
      if (rst) begin
        phase[i] = 0; period[i] = 1; high[i] = 0;
        pperiod[i] = 1; phigh[i] = 0; pend[i] = 0;
        m_ce[i] = 0; m_clk[i] = 0;
      end else begin
        at_end   = en[i] && (phase[i] == period[i] - 1);
        moving   = at_end || sync || !en[i];
        m_ce[i]  = at_end && !sync;
        m_clk[i] = en[i] && (phase[i] < high[i]);
        phase[i] = (!en[i] || sync) ? 0 : (phase[i] + 1) % period[i];
        if (load[i]) begin
          pperiod[i] = d + 1; phigh[i] = h;
          if (moving) begin period[i] = d + 1; high[i] = h; pend[i] = 0; end
          else pend[i] = 1;
        end else if (moving && pend[i]) begin
          period[i] = pperiod[i]; high[i] = phigh[i]; pend[i] = 0;
        end
      end
      m_pend[i] = pend[i];
    end
  endtask

  task automatic check_outs();
    n_chk++;
    assert (ce_o === m_ce) else begin
      n_fail++; $error("FAIL ce_o obs=%b exp=%b t=%0t", ce_o, m_ce, $time);
    end
    n_chk++;
    assert (clk_o === m_clk) else begin
      n_fail++; $error("FAIL clk_o obs=%b exp=%b t=%0t", clk_o, m_clk, $time);
    end
    n_chk++;
    assert (pend_o === m_pend) else begin
      n_fail++; $error("FAIL pend_o obs=%b exp=%b t=%0t", pend_o, m_pend, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic set_cfg(input int ch, input int d, input int h);
    div_i[ch*CW +: CW]  = CW'(d);
    high_i[ch*CW +: CW] = CW'(h);
    load[ch] = 1'b1;
  endtask

  initial begin
    int k;
    // Reset state
    rst = 1'b1;
    run(2);
    n_chk++;
    assert ({ce_o, clk_o, pend_o} === '0) else begin
      n_fail++; $error("FAIL reset_outs obs=%b exp=0", {ce_o, clk_o, pend_o});
    end
    rst = 1'b0;
    cyc();

    // ch0 div=4 high=2, first ce 5 cycles after en rises
    set_cfg(0, 4, 2);
    cyc();
    load = '0;
    en[0] = 1'b1;
    k = 0;
    do begin cyc(); k++; end while (ce_o[0] !== 1'b1 && k < 20);
    n_chk++;
    assert (k == 5) else begin
      n_fail++; $error("FAIL first_ce_latency obs=%0d exp=5", k);
    end
    run(7);

    // Reconfigure mid-period: pending held until terminal
    cyc();
    set_cfg(0, 9, 5);
    cyc();
    load = '0;
    n_chk++;
    assert (pend_o[0] === 1'b1) else begin
      n_fail++; $error("FAIL pend_after_load obs=%b exp=1", pend_o[0]);
    end
    run(25);

    // ch0/ch1 div=3 started two cycles apart, then sync
    set_cfg(0, 3, 1); set_cfg(1, 3, 2);
    en[1:0] = 2'b00;
    cyc();
    load = '0;
    en[0] = 1'b1; run(2);
    en[1] = 1'b1; run(5);
    sync = 1'b1; cyc();
    sync = 1'b0;
    n_chk++;
    assert (ce_o[1:0] === 2'b00) else begin
      n_fail++; $error("FAIL sync_cycle_ce obs=%b exp=00", ce_o[1:0]);
    end
    run(3);
    cyc();
    n_chk++;
    assert (ce_o[1:0] === 2'b11) else begin
      n_fail++; $error("FAIL sync_coincide obs=%b exp=11", ce_o[1:0]);
    end
    run(4);

    // Duty extremes and div=0
    en[3:2] = 2'b00;
    set_cfg(2, 4, 0); set_cfg(3, 4, 7);
    cyc();
    load = '0; en[3:2] = 2'b11;
    run(12);
    set_cfg(0, 0, 1);
    cyc();
    load = '0;
    run(6);
    n_chk++;
    assert (ce_o[0] === 1'b1 && clk_o[0] === 1'b1 && clk_o[2] === 1'b0 && clk_o[3] === 1'b1)
    else begin
      n_fail++; $error("FAIL duty_extremes obs=%b%b%b%b exp=1101", ce_o[0], clk_o[0], clk_o[2], clk_o[3]);
    end

    // Load coincident with terminal, div=2
    set_cfg(1, 2, 1);
    cyc(); load = '0;
    run(3);
    while (!(m_ce[1] == 0 && phase[1] == 2)) cyc();
    set_cfg(1, 5, 3);
    cyc(); load = '0;
    n_chk++;
    assert (pend_o[1] === 1'b0) else begin
      n_fail++; $error("FAIL load_at_terminal_pend obs=%b exp=0", pend_o[1]);
    end
    run(14);

    // Reset mid-period with div=6 loaded
    set_cfg(0, 6, 3);
    cyc(); load = '0;
    run(3);
    rst = 1'b1; cyc(); rst = 1'b0;
    n_chk++;
    assert ({ce_o, clk_o, pend_o} === '0) else begin
      n_fail++; $error("FAIL midrst_outs obs=%b exp=0", {ce_o, clk_o, pend_o});
    end
    run(3);
    n_chk++;
    assert (ce_o === {NCH{1'b1}} && clk_o === '0) else begin
      n_fail++; $error("FAIL post_rst_run obs=%b/%b exp=1111/0000", ce_o, clk_o);
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        en[i]   = ($urandom_range(0, 19) != 0);
        load[i] = ($urandom_range(0, 11) == 0);
        div_i[i*CW +: CW]  = CW'($urandom_range(0, 12));
        high_i[i*CW +: CW] = CW'($urandom_range(0, 14));
      end
      sync = ($urandom_range(0, 39) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
